// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, port IDs, latency limit.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  typedef logic port_id_t;

  localparam port_id_t PORT_CORE   = 1'b0;
  localparam port_id_t PORT_LOADER = 1'b1;

  localparam int MAX_MEM_LAT = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way picker: fixed loader priority or alternate-on-contention round robin.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_winner,
  input  logic       prio_mode,
  output port_id_t   winner
);

  // Loader wins when it asks and either has priority, is alone, or the core won last.
  always_comb begin
    winner = PORT_CORE;
    if (req[PORT_LOADER] &&
        (prio_mode || !req[PORT_CORE] || (last_winner == PORT_CORE))) begin
      winner = PORT_LOADER;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the core and the loader, one transaction at a time.
// Latency: req to rvalid is MEM_LAT+2 cycles for reads, 2 cycles for writes.
// Backpressure: a requester holds req until its one-cycle gnt; the loser simply waits.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LAT     = 1,
  parameter int LOADER_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int                CNT_W    = $clog2(MAX_MEM_LAT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LAT - 1);
  localparam logic              PRIO     = (LOADER_PRIO != 0);

  if ((MEM_LAT < 1) || (MEM_LAT > MAX_MEM_LAT)) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be within 1..4");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  port_id_t          last_winner_q, last_winner_d, winner;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic              m_en_q, m_en_d, m_we_q, m_we_d;
  logic              c_gnt_q, c_gnt_d, l_gnt_q, l_gnt_d;
  logic              c_rvalid_q, c_rvalid_d, l_rvalid_q, l_rvalid_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d, l_rdata_q, l_rdata_d;
  logic              busy_q, busy_d;
  logic              take, rd_ld;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arb2 u_arb (
    .req         ({l_req, c_req}),
    .last_winner (last_winner_q),
    .prio_mode   (PRIO),
    .winner      (winner)
  );

  assign take      = (state_q == IDLE) && (c_req || l_req);
  assign rd_ld     = (state_q == WAIT) && (cnt_q == CNT_LAST);
  assign win_we    = (winner == PORT_LOADER) ? l_we    : c_we;
  assign win_addr  = (winner == PORT_LOADER) ? l_addr  : c_addr;
  assign win_wdata = (winner == PORT_LOADER) ? l_wdata : c_wdata;

  // State register; reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and read-latency counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE:  if (c_req || l_req) state_d = ISSUE;
      ISSUE: begin
        state_d = we_q ? RESP : WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) state_d = RESP;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      RESP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output next values: decoded from the upcoming state so every output is a flop.
  always_comb begin
    last_winner_d = take ? winner    : last_winner_q;
    we_d          = take ? win_we    : we_q;
    m_addr_d      = take ? win_addr  : m_addr_q;
    m_wdata_d     = take ? win_wdata : m_wdata_q;
    m_en_d        = (state_d == ISSUE);
    m_we_d        = m_en_d && we_d;
    c_gnt_d       = m_en_d && (last_winner_d == PORT_CORE);
    l_gnt_d       = m_en_d && (last_winner_d == PORT_LOADER);
    c_rvalid_d    = (state_d == RESP) && (last_winner_d == PORT_CORE);
    l_rvalid_d    = (state_d == RESP) && (last_winner_d == PORT_LOADER);
    c_rdata_d     = (rd_ld && (last_winner_q == PORT_CORE))   ? m_rdata : c_rdata_q;
    l_rdata_d     = (rd_ld && (last_winner_q == PORT_LOADER)) ? m_rdata : l_rdata_q;
    busy_d        = (state_d != IDLE);
  end

  // Capture, counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q         <= '0;
      last_winner_q <= PORT_LOADER;
      we_q          <= 1'b0;
      m_addr_q      <= '0;
      m_wdata_q     <= '0;
      m_en_q        <= 1'b0;
      m_we_q        <= 1'b0;
      c_gnt_q       <= 1'b0;
      l_gnt_q       <= 1'b0;
      c_rvalid_q    <= 1'b0;
      l_rvalid_q    <= 1'b0;
      c_rdata_q     <= '0;
      l_rdata_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      last_winner_q <= last_winner_d;
      we_q          <= we_d;
      m_addr_q      <= m_addr_d;
      m_wdata_q     <= m_wdata_d;
      m_en_q        <= m_en_d;
      m_we_q        <= m_we_d;
      c_gnt_q       <= c_gnt_d;
      l_gnt_q       <= l_gnt_d;
      c_rvalid_q    <= c_rvalid_d;
      l_rvalid_q    <= l_rvalid_d;
      c_rdata_q     <= c_rdata_d;
      l_rdata_q     <= l_rdata_d;
      busy_q        <= busy_d;
    end
  end

  assign c_gnt    = c_gnt_q;
  assign c_rvalid = c_rvalid_q;
  assign c_rdata  = c_rdata_q;
  assign l_gnt    = l_gnt_q;
  assign l_rvalid = l_rvalid_q;
  assign l_rdata  = l_rdata_q;
  assign m_en     = m_en_q;
  assign m_we     = m_we_q;
  assign m_addr   = m_addr_q;
  assign m_wdata  = m_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (lat1/rr, lat4/prio, lat3/rr).
// Latency: each instance has a behavioural memory with a MEM_LAT-deep read pipe.
// Backpressure: requests are held until gnt, then dropped.
module tb_mem_port_arbiter;

  localparam int N = 3;
  localparam int LAT_CFG  [N] = '{1, 4, 3};
  localparam int PRIO_CFG [N] = '{0, 1, 0};
  localparam logic [31:0] INSN = 32'h0050_0093;

  logic        clk;
  logic        rst_n   [N];
  logic        c_req   [N], c_we [N], l_req [N], l_we [N];
  logic [31:0] c_addr  [N], c_wdata [N], l_addr [N], l_wdata [N];
  logic        c_gnt   [N], c_rvalid [N], l_gnt [N], l_rvalid [N];
  logic [31:0] c_rdata [N], l_rdata [N];
  logic        m_en    [N], m_we [N], busy [N];
  logic [31:0] m_addr  [N], m_wdata [N], m_rdata [N];

  int n_cmp = 0;
  int n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    logic [31:0] mem  [16];
    logic [31:0] pipe [4];
    bit          loaded = 1'b0;

    mem_port_arbiter #(
      .ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_CFG[g]), .LOADER_PRIO(PRIO_CFG[g])
    ) u_dut (
      .clk(clk), .reset(rst_n[g]),
      .c_req(c_req[g]), .c_we(c_we[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_gnt(c_gnt[g]), .c_rvalid(c_rvalid[g]), .c_rdata(c_rdata[g]),
      .l_req(l_req[g]), .l_we(l_we[g]), .l_addr(l_addr[g]), .l_wdata(l_wdata[g]),
      .l_gnt(l_gnt[g]), .l_rvalid(l_rvalid[g]), .l_rdata(l_rdata[g]),
      .m_en(m_en[g]), .m_we(m_we[g]), .m_addr(m_addr[g]), .m_wdata(m_wdata[g]),
      .m_rdata(m_rdata[g]), .busy(busy[g])
    );

    // Synchronous memory; read data emerges MEM_LAT cycles after the m_en cycle,
    // with a poison value on every other cycle to expose mistimed sampling.
    always @(posedge clk) begin
      if (!loaded) begin
        for (int i = 0; i < 16; i++) mem[i] <= (i == 4) ? INSN : 32'h0;
        loaded <= 1'b1;
      end else if (m_en[g] && m_we[g]) begin
        mem[m_addr[g][5:2]] <= m_wdata[g];
      end
      pipe[0] <= (m_en[g] && !m_we[g]) ? mem[m_addr[g][5:2]] : 32'hBAD0_0BAD;
      for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
    end

    assign m_rdata[g] = pipe[LAT_CFG[g]-1];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int g);
    for (int i = 0; i < 20 && busy[g]; i++) tick();
    chk("wait_idle", {31'b0, busy[g]}, 32'h0);
  endtask

  task automatic start_req(input int g, input logic is_l, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata);
    if (is_l) begin
      l_req[g] = 1'b1; l_we[g] = we; l_addr[g] = addr; l_wdata[g] = wdata;
    end else begin
      c_req[g] = 1'b1; c_we[g] = we; c_addr[g] = addr; c_wdata[g] = wdata;
    end
  endtask

  initial begin : stim
    int   n0, n1;
    logic [3:0] ord0, ord1;
    logic both, seen;

    for (int g = 0; g < N; g++) begin
      rst_n[g] = 1'b0;
      c_req[g] = 1'b0; c_we[g] = 1'b0; c_addr[g] = 32'h0; c_wdata[g] = 32'h0;
      l_req[g] = 1'b0; l_we[g] = 1'b0; l_addr[g] = 32'h0; l_wdata[g] = 32'h0;
    end
    // Reset held with both requesters active on instances 0 and 1
    for (int g = 0; g < 2; g++) begin c_req[g] = 1'b1; l_req[g] = 1'b1; end
    repeat (3) tick();
    chk("rst_c_gnt",    {31'b0, c_gnt[0]},    32'h0);
    chk("rst_l_gnt",    {31'b0, l_gnt[0]},    32'h0);
    chk("rst_m_en",     {31'b0, m_en[0]},     32'h0);
    chk("rst_busy",     {31'b0, busy[0]},     32'h0);
    chk("rst_c_rvalid", {31'b0, c_rvalid[0]}, 32'h0);
    chk("rst_c_rdata",  c_rdata[0],           32'h0);
    chk("rst_m_addr",   m_addr[1],            32'h0);
    chk("rst_busy1",    {31'b0, busy[1]},     32'h0);

    // Contention: record four grants on each instance (bit i = 1 means loader)
    for (int g = 0; g < N; g++) rst_n[g] = 1'b1;
    n0 = 0; n1 = 0; ord0 = '0; ord1 = '0; both = 1'b0;
    for (int cyc = 0; cyc < 80 && (n0 < 4 || n1 < 4); cyc++) begin
      tick();
      if ((c_gnt[0] || l_gnt[0]) && n0 < 4) begin
        ord0[n0] = l_gnt[0]; n0++;
        if (n0 == 4) begin c_req[0] = 1'b0; l_req[0] = 1'b0; end
      end
      if ((c_gnt[1] || l_gnt[1]) && n1 < 4) begin
        ord1[n1] = l_gnt[1]; n1++;
        if (n1 == 4) begin c_req[1] = 1'b0; l_req[1] = 1'b0; end
      end
      if ((c_gnt[0] && l_gnt[0]) || (c_gnt[1] && l_gnt[1])) both = 1'b1;
    end
    chk("grants_rr",   n0, 4);
    chk("grants_prio", n1, 4);
    chk("order_rr",    {28'b0, ord0}, 32'h0000_000A);
    chk("order_prio",  {28'b0, ord1}, 32'h0000_000F);
    chk("dual_gnt",    {31'b0, both}, 32'h0);
    wait_idle(0);
    wait_idle(1);

    // Core read of 0x10 with MEM_LAT=1
    start_req(0, 1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    c_req[0] = 1'b0;
    chk("rd_c_gnt",  {31'b0, c_gnt[0]}, 32'h1);
    chk("rd_l_gnt",  {31'b0, l_gnt[0]}, 32'h0);
    chk("rd_m_en",   {31'b0, m_en[0]},  32'h1);
    chk("rd_m_we",   {31'b0, m_we[0]},  32'h0);
    chk("rd_m_addr", m_addr[0],         32'h10);
    tick();
    chk("rd_wait_rvalid", {31'b0, c_rvalid[0]}, 32'h0);
    chk("rd_wait_m_en",   {31'b0, m_en[0]},     32'h0);
    tick();
    chk("rd_c_rvalid", {31'b0, c_rvalid[0]}, 32'h1);
    chk("rd_c_rdata",  c_rdata[0],           INSN);
    chk("rd_l_rvalid", {31'b0, l_rvalid[0]}, 32'h0);
    chk("rd_l_rdata",  l_rdata[0],           32'h0);
    tick();
    chk("rd_done_rvalid", {31'b0, c_rvalid[0]}, 32'h0);
    chk("rd_done_busy",   {31'b0, busy[0]},     32'h0);
    chk("rd_hold_rdata",  c_rdata[0],           INSN);

    // Loader write of 0xDEADBEEF to 0x4, then core reads it back
    start_req(0, 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF);
    tick();
    l_req[0] = 1'b0;
    chk("wr_l_gnt",   {31'b0, l_gnt[0]}, 32'h1);
    chk("wr_m_en",    {31'b0, m_en[0]},  32'h1);
    chk("wr_m_we",    {31'b0, m_we[0]},  32'h1);
    chk("wr_m_addr",  m_addr[0],         32'h4);
    chk("wr_m_wdata", m_wdata[0],        32'hDEAD_BEEF);
    tick();
    chk("wr_l_rvalid", {31'b0, l_rvalid[0]}, 32'h1);
    chk("wr_m_en_off", {31'b0, m_en[0]},     32'h0);
    chk("wr_m_we_off", {31'b0, m_we[0]},     32'h0);
    chk("wr_l_rdata",  l_rdata[0],           32'h0);
    chk("wr_c_rdata",  c_rdata[0],           INSN);
    tick();
    chk("wr_done_busy", {31'b0, busy[0]}, 32'h0);
    start_req(0, 1'b0, 1'b0, 32'h4, 32'h0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) c_req[0] = 1'b0;
      chk("rb_c_rvalid", {31'b0, c_rvalid[0]}, {31'b0, (k == 3)});
      if (k == 3) chk("rb_c_rdata", c_rdata[0], 32'hDEAD_BEEF);
    end

    // MEM_LAT=4 core read: busy over cycles 1..6, rvalid at cycle 6
    start_req(1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) c_req[1] = 1'b0;
      chk("lat4_busy",   {31'b0, busy[1]},     {31'b0, (k <= 6)});
      chk("lat4_rvalid", {31'b0, c_rvalid[1]}, {31'b0, (k == 6)});
      if (k == 6) chk("lat4_rdata", c_rdata[1], INSN);
    end

    // MEM_LAT=3: reset in WAIT discards the read
    start_req(2, 1'b0, 1'b0, 32'h10, 32'h0);
    tick();
    c_req[2] = 1'b0;
    chk("lat3_gnt", {31'b0, c_gnt[2]}, 32'h1);
    tick();
    tick();
    chk("lat3_in_wait", {31'b0, busy[2]}, 32'h1);
    rst_n[2] = 1'b0;
    #1;
    chk("lat3_rst_busy", {31'b0, busy[2]}, 32'h0);
    chk("lat3_rst_m_en", {31'b0, m_en[2]}, 32'h0);
    seen = 1'b0;
    repeat (2) begin tick(); seen = seen | c_rvalid[2]; end
    rst_n[2] = 1'b1;
    repeat (4) begin tick(); seen = seen | c_rvalid[2] | busy[2]; end
    chk("lat3_no_rvalid", {31'b0, seen}, 32'h0);
    chk("lat3_rdata_clr", c_rdata[2],    32'h0);
    start_req(2, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) c_req[2] = 1'b0;
      chk("lat3_rvalid", {31'b0, c_rvalid[2]}, {31'b0, (k == 5)});
      if (k == 5) chk("lat3_rdata", c_rdata[2], INSN);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
